// File: rtl/soup_io_pkg.sv
// Shared constants for the SoupVenture pad-side I/O controller.
// Also provides the 7-segment hex glyphs that the game core uses to fill the frame.
package soup_io_pkg;

  localparam int N_IN_DEF     = 9;
  localparam int SEG_W_DEF    = 8;
  localparam int N_DIGITS_DEF = 8;
  localparam int DB_LIMIT_DEF = 50000;
  localparam int SCAN_DIV_DEF = 1000;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high segments, bit order {dp, g, f, e, d, c, b, a}.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [7:0] seg_hex(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/soup_debounce.sv
// One button bit: 2-flop synchroniser, optional debouncer, rising-edge press pulse.
// The debouncer is built only when SOUP_IO_DEBOUNCE_EN is defined.
module soup_debounce
  import soup_io_pkg::*;
#(
  parameter int DB_LIMIT = DB_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic level_o,
  output logic press_o
);

  logic meta_q, sync_q, stable, stable_dly_q, press_q;

  // NOTE: clocked state always uses <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
    end
  end

`ifdef SOUP_IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    // NOTE: defaults first so every path assigns; a missed branch would infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DB_LIMIT - 1)) stable_d = sync_q;
      else                               cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      press_q      <= stable & ~stable_dly_q;
    end
  end

  assign level_o = stable;
  assign press_o = press_q;

endmodule

// File: rtl/soup_io_ctrl.sv
// SoupVenture pad I/O controller: debounced buttons in, double-buffered multiplexed display out.
// Input debouncing is enabled by defining SOUP_IO_DEBOUNCE_EN; otherwise buttons are only synchronised.
module soup_io_ctrl
  import soup_io_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int SEG_W    = SEG_W_DEF,
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int DB_LIMIT = DB_LIMIT_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [N_IN-1:0]             io_in,
  output logic [SEG_W+N_DIGITS-1:0]   io_out,
  output logic [SEG_W+N_DIGITS-1:0]   io_oeb,
  output logic [N_IN-1:0]             btn_level_o,
  output logic [N_IN-1:0]             btn_press_o,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [$clog2(N_DIGITS)-1:0] wr_idx_i,
  input  logic [SEG_W-1:0]            wr_data_i,
  input  logic                        commit_i
);

  localparam int N_OUT = SEG_W + N_DIGITS;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam logic [IDX_W:0] N_DIGITS_L = (IDX_W + 1)'(N_DIGITS);

  for (genvar i = 0; i < N_IN; i++) begin : g_btn
    soup_debounce #(.DB_LIMIT(DB_LIMIT)) u_debounce (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .pad_i  (io_in[i]),
      .level_o(btn_level_o[i]),
      .press_o(btn_press_o[i])
    );
  end

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [SEG_W-1:0] front_q [N_DIGITS];
  logic [SEG_W-1:0] front_d [N_DIGITS];
  logic [SEG_W-1:0] back_q  [N_DIGITS];
  logic [SEG_W-1:0] back_d  [N_DIGITS];
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [N_OUT-1:0] out_q, out_d, oeb_q;
  logic             tick, wrap;
  logic [N_DIGITS-1:0] sel_d;
  logic [SEG_W-1:0]    seg_d;

  assign tick = (presc_q == PS_W'(SCAN_DIV - 1));
  assign wrap = tick && (ptr_q == IDX_W'(N_DIGITS - 1));

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    ptr_d     = ptr_q;
    back_d    = back_q;
    front_d   = front_q;
    pending_d = pending_q;

    if (tick) ptr_d = wrap ? '0 : ptr_q + 1'b1;

    if (wr_valid_i && ready_q && ({1'b0, wr_idx_i} < N_DIGITS_L))
      back_d[wr_idx_i] = wr_data_i;

    if (commit_i && ready_q) pending_d = 1'b1;

    // Swap only at frame end so a displayed frame is never a mix of two commits.
    if (pending_q && wrap) begin
      front_d   = back_q;
      pending_d = 1'b0;
    end
    ready_d = ~pending_d;

    // Output is built from next-state values so the registered pads line up with the scan state.
    sel_d = N_DIGITS'(1) << ptr_d;
    seg_d = (presc_d == '0) ? SEG_W'(SEG_BLANK) : front_d[ptr_d];
    out_d = {sel_d, seg_d};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      presc_q   <= '0;
      ptr_q     <= '0;
      // NOTE: the frame buffers are small register arrays, so they get a real reset to a blank frame.
      front_q   <= '{default: '0};
      back_q    <= '{default: '0};
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      out_q     <= '0;
      oeb_q     <= '1;
    end else begin
      presc_q   <= presc_d;
      ptr_q     <= ptr_d;
      front_q   <= front_d;
      back_q    <= back_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      out_q     <= out_d;
      oeb_q     <= '0;
    end
  end

  assign io_out     = out_q;
  assign io_oeb     = oeb_q;
  assign wr_ready_o = ready_q;

endmodule

// File: tb/tb_soup_io_ctrl.sv
// Directed bench for soup_io_ctrl: reset, buttons, frame write/commit, back-pressure, out-of-range index.
// Button latency expectations follow SOUP_IO_DEBOUNCE_EN.
module tb_soup_io_ctrl;

`ifdef SOUP_IO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  localparam logic [7:0] PAT  [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
  localparam logic [3:0] SEL4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  localparam logic [2:0] SEL3 [3] = '{3'b001, 3'b010, 3'b100};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  io_in = '0;
  logic [11:0] io_out, io_oeb;
  logic [8:0]  btn_level, btn_press;
  logic        wr_valid = 1'b0, wr_ready, commit = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [7:0]  wr_data = '0;

  logic [8:0]  io_in2 = '0;
  logic [10:0] io_out2, io_oeb2;
  logic [8:0]  btn_level2, btn_press2;
  logic        wr_valid2 = 1'b0, wr_ready2, commit2 = 1'b0;
  logic [1:0]  wr_idx2 = '0;
  logic [7:0]  wr_data2 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  soup_io_ctrl #(.N_IN(9), .SEG_W(8), .N_DIGITS(4), .DB_LIMIT(4), .SCAN_DIV(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .btn_level_o(btn_level), .btn_press_o(btn_press), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .commit_i(commit)
  );

  soup_io_ctrl #(.N_IN(9), .SEG_W(8), .N_DIGITS(3), .DB_LIMIT(4), .SCAN_DIV(4)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io_in2), .io_out(io_out2), .io_oeb(io_oeb2),
    .btn_level_o(btn_level2), .btn_press_o(btn_press2), .wr_valid_i(wr_valid2),
    .wr_ready_o(wr_ready2), .wr_idx_i(wr_idx2), .wr_data_i(wr_data2), .commit_i(commit2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the first (blanked) cycle of digit slot d.
  task automatic wait_digit(input int d, output bit ok);
    int i = 0;
    while (io_out[11:8] == SEL4[d] && i < 64) begin step; i++; end
    while (io_out[11:8] != SEL4[d] && i < 128) begin step; i++; end
    ok = (io_out[11:8] == SEL4[d]);
  endtask

  task automatic wait_ready(output bit ok);
    int i = 0;
    while (wr_ready !== 1'b1 && i < 40) begin step; i++; end
    ok = (wr_ready === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) step;
    rst = 1'b0;
    repeat (10) step;
    commit = 1'b1; step; commit = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pending_before: wr_ready_o=%b required 0", wr_ready); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (io_oeb !== 12'hFFF) begin n_errors++; $display("FAIL reset_oeb: io_oeb=%h required fff", io_oeb); end
    n_checks++;
    if (io_out !== 12'h000) begin n_errors++; $display("FAIL reset_out: io_out=%h required 000", io_out); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: wr_ready_o=%b required 1", wr_ready); end
    n_checks++;
    if ({btn_level, btn_press} !== 18'h0) begin n_errors++; $display("FAIL reset_btn: level=%h press=%h required 0", btn_level, btn_press); end
    step;
    rst = 1'b0;
    n_checks++;
    if (io_oeb !== 12'hFFF) begin n_errors++; $display("FAIL reset_oeb_release: io_oeb=%h required fff", io_oeb); end
    step;
    n_checks++;
    if (io_oeb !== 12'h000) begin n_errors++; $display("FAIL oeb_after_release: io_oeb=%h required 000", io_oeb); end
    n_checks++;
    if (io_out !== 12'h100) begin n_errors++; $display("FAIL out_after_release: io_out=%h required 100", io_out); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_release: wr_ready_o=%b required 1", wr_ready); end
  endtask

  task automatic test_press(input int b);
    io_in[b] = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      step;
      n_checks++;
      if ({btn_level[b], btn_press[b]} !== {(c == LAT), 1'b0}) begin
        n_errors++;
        $display("FAIL press%0d_rise_c%0d: level,press=%b%b required %b0", b, c, btn_level[b], btn_press[b], (c == LAT));
      end
    end
    step;
    n_checks++;
    if ({btn_level[b], btn_press[b]} !== 2'b11) begin n_errors++; $display("FAIL press%0d_pulse: level,press=%b%b required 11", b, btn_level[b], btn_press[b]); end
    step;
    n_checks++;
    if ({btn_level[b], btn_press[b]} !== 2'b10) begin n_errors++; $display("FAIL press%0d_pulse_end: level,press=%b%b required 10", b, btn_level[b], btn_press[b]); end
    io_in[b] = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      step;
      n_checks++;
      if (btn_press[b] !== 1'b0) begin n_errors++; $display("FAIL press%0d_fall_c%0d: press=%b required 0", b, c, btn_press[b]); end
    end
    n_checks++;
    if (btn_level[b] !== 1'b0) begin n_errors++; $display("FAIL press%0d_released: level=%b required 0", b, btn_level[b]); end
  endtask

`ifdef SOUP_IO_DEBOUNCE_EN
  task automatic test_glitch;
    io_in[1] = 1'b1;
    repeat (3) step;
    io_in[1] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step;
      n_checks++;
      if ({btn_level[1], btn_press[1]} !== 2'b00) begin
        n_errors++;
        $display("FAIL glitch_c%0d: level,press=%b%b required 00", c, btn_level[1], btn_press[1]);
      end
    end
  endtask
`endif

  task automatic test_write_commit;
    bit ok;
    int i;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL wc_ready_idle: wr_ready_o=%b required 1", wr_ready); end
    for (int d = 0; d < 4; d++) begin
      wr_valid = 1'b1; wr_idx = 2'(d); wr_data = PAT[d]; commit = (d == 3);
      step;
    end
    wr_valid = 1'b0; commit = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL wc_ready_drop: wr_ready_o=%b required 0", wr_ready); end
    i = 0;
    while (wr_ready !== 1'b1 && i < 40) begin
      n_checks++;
      if (io_out[7:0] !== 8'h00) begin n_errors++; $display("FAIL wc_pre_swap: segments=%h required 00", io_out[7:0]); end
      step; i++;
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL wc_ready_timeout: wr_ready_o=%b required 1", wr_ready); end
    n_checks++;
    if (io_out !== 12'h100) begin n_errors++; $display("FAIL wc_swap_blank: io_out=%h required 100", io_out); end
    step;
    n_checks++;
    if (io_out !== 12'h13F) begin n_errors++; $display("FAIL wc_digit0: io_out=%h required 13f", io_out); end
    for (int d = 1; d < 4; d++) begin
      repeat (3) step;
      n_checks++;
      if (io_out !== {SEL4[d], 8'h00}) begin n_errors++; $display("FAIL wc_blank%0d: io_out=%h required %h", d, io_out, {SEL4[d], 8'h00}); end
      step;
      n_checks++;
      if (io_out !== {SEL4[d], PAT[d]}) begin n_errors++; $display("FAIL wc_digit%0d: io_out=%h required %h", d, io_out, {SEL4[d], PAT[d]}); end
    end
    ok = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 8'h66;
    step;
    wr_valid = 1'b0; commit = 1'b1;
    step;
    commit = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_drop: wr_ready_o=%b required 0", wr_ready); end
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 8'h7D;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_ready_timeout: wr_ready_o=%b required 1", wr_ready); end
    step;
    wr_valid = 1'b0;
    wait_digit(1, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_digit1_timeout: select=%b required 0010", io_out[11:8]); end
    step;
    n_checks++;
    if (io_out !== 12'h266) begin n_errors++; $display("FAIL bp_front_kept: io_out=%h required 266", io_out); end
    commit = 1'b1; step; commit = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_ready2_timeout: wr_ready_o=%b required 1", wr_ready); end
    wait_digit(1, ok);
    step;
    n_checks++;
    if (io_out !== 12'h27D) begin n_errors++; $display("FAIL bp_late_write: io_out=%h required 27d", io_out); end
  endtask

  task automatic test_out_of_range;
    int i;
    n_checks++;
    if (wr_ready2 !== 1'b1) begin n_errors++; $display("FAIL oor_ready_before: wr_ready_o=%b required 1", wr_ready2); end
    wr_valid2 = 1'b1; wr_idx2 = 2'd3; wr_data2 = 8'hFF;
    step;
    wr_valid2 = 1'b0;
    n_checks++;
    if (wr_ready2 !== 1'b1) begin n_errors++; $display("FAIL oor_ready_after: wr_ready_o=%b required 1", wr_ready2); end
    commit2 = 1'b1; step; commit2 = 1'b0;
    n_checks++;
    if (wr_ready2 !== 1'b0) begin n_errors++; $display("FAIL oor_ready_drop: wr_ready_o=%b required 0", wr_ready2); end
    i = 0;
    while (wr_ready2 !== 1'b1 && i < 40) begin step; i++; end
    n_checks++;
    if (wr_ready2 !== 1'b1) begin n_errors++; $display("FAIL oor_ready_timeout: wr_ready_o=%b required 1", wr_ready2); end
    n_checks++;
    if (io_out2 !== 11'h100) begin n_errors++; $display("FAIL oor_swap: io_out=%h required 100", io_out2); end
    for (int c = 1; c <= 12; c++) begin
      step;
      n_checks++;
      if (io_out2 !== {SEL3[(c / 4) % 3], 8'h00}) begin
        n_errors++;
        $display("FAIL oor_scan_c%0d: io_out=%h required %h", c, io_out2, {SEL3[(c / 4) % 3], 8'h00});
      end
    end
  endtask

  initial begin
    test_reset();
    test_press(0);
`ifdef SOUP_IO_DEBOUNCE_EN
    test_glitch();
`endif
    test_press(2);
    test_write_commit();
    test_back_to_back();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
